// File: rtl/plic_pkg.sv
// Shared sizing helpers for the PLIC fan-in tree and the claim logic that sits
// after it.
package plic_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) r++;
        return r;
    endfunction

    // Width of a device ID; ID 0 is reserved for "no interrupt".
    function automatic int idw(input int n_src);
        return clog2(n_src + 1);
    endfunction

    function automatic int latency(input int n_src, input int lvl_per_stage);
        int l;
        l = (clog2(n_src) + lvl_per_stage - 1) / lvl_per_stage;
        return (l < 1) ? 1 : l;
    endfunction

endpackage

// File: rtl/plic_fan_in_pipe_if.sv
// Source-side inputs and context-side results of one PLIC fan-in instance.
interface plic_fan_in_pipe_if #(
    parameter int N_SRC  = 8,
    parameter int PRIO_W = 3
);
    localparam int IDW = plic_pkg::idw(N_SRC);

    logic [N_SRC-1:0]             ip;
    logic [N_SRC-1:0]             en;
    logic [N_SRC-1:0][PRIO_W-1:0] prio;
    logic [PRIO_W-1:0]            threshold;
    logic                         stall;
    logic [IDW-1:0]               dev;
    logic [PRIO_W-1:0]            max;
    logic                         eip;
    logic                         out_valid;

    modport master (
        output ip, en, prio, threshold, stall,
        input  dev, max, eip, out_valid
    );

    modport slave (
        input  ip, en, prio, threshold, stall,
        output dev, max, eip, out_valid
    );
endinterface

// File: rtl/plic_cmp_node.sv
// One node of the fan-in tree: candidates are {prio, id} with prio in the MSBs.
module plic_cmp_node #(
    parameter int PRIO_W = 3,
    parameter int IDW    = 4
) (
    input  logic [PRIO_W+IDW-1:0] a_i,
    input  logic [PRIO_W+IDW-1:0] b_i,
    output logic [PRIO_W+IDW-1:0] y_o
);
    localparam int CW = PRIO_W + IDW;

    // Strict compare keeps the left input on ties, so the lower device ID wins.
    assign y_o = (b_i[CW-1 -: PRIO_W] > a_i[CW-1 -: PRIO_W]) ? b_i : a_i;
endmodule

// File: rtl/plic_fan_in_pipe.sv
// Pipelined highest-priority selection over N_SRC sources with threshold compare
// producing the context's external-interrupt request.
module plic_fan_in_pipe
    import plic_pkg::*;
#(
    parameter int N_SRC         = 8,
    parameter int PRIO_W        = 3,
    parameter int LVL_PER_STAGE = 2
) (
    input logic               clock,
    input logic               reset_n,
    plic_fan_in_pipe_if.slave bus
);
    localparam int IDW     = idw(N_SRC);
    localparam int D       = clog2(N_SRC);
    localparam int NP      = 1 << D;
    localparam int LATENCY = latency(N_SRC, LVL_PER_STAGE);
    localparam int CNT_W   = clog2(LATENCY + 1);

    typedef struct packed {
        logic [PRIO_W-1:0] prio;
        logic [IDW-1:0]    id;
    } plic_cand_t;

    // Level 0 holds the (padded) leaves; level D holds the single root.
    for (genvar l = 0; l <= D; l++) begin : g_lvl
        localparam int NN = NP >> l;
        plic_cand_t [NN-1:0] v;

        for (genvar n = 0; n < NN; n++) begin : g_n
            if (l == 0) begin : g_leaf
                if (n < N_SRC) begin : g_src
                    logic hit;
                    assign hit       = bus.ip[n] & bus.en[n] & (bus.prio[n] != '0);
                    assign v[n].prio = hit ? bus.prio[n] : '0;
                    assign v[n].id   = hit ? IDW'(n + 1) : '0;
                end else begin : g_pad
                    assign v[n] = '0;
                end
            end else begin : g_cmp
                plic_cand_t node_d;

                plic_cmp_node #(
                    .PRIO_W (PRIO_W),
                    .IDW    (IDW)
                ) u_cmp (
                    .a_i (g_lvl[l-1].v[2*n]),
                    .b_i (g_lvl[l-1].v[2*n+1]),
                    .y_o (node_d)
                );

                // A boundary on the root level is absorbed by the output register.
                if ((l % LVL_PER_STAGE == 0) && (l < D)) begin : g_reg
                    plic_cand_t node_q;
                    always_ff @(posedge clock or negedge reset_n) begin
                        if (!reset_n)        node_q <= '0;
                        else if (!bus.stall) node_q <= node_d;
                    end
                    assign v[n] = node_q;
                end else begin : g_comb
                    assign v[n] = node_d;
                end
            end
        end
    end

    plic_cand_t        root;
    logic [IDW-1:0]    dev_q;
    logic [PRIO_W-1:0] max_q;
    logic              eip_q;
    logic              eip_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    assign root  = g_lvl[D].v[0];
    assign eip_d = root.prio > bus.threshold;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != CNT_W'(LATENCY)) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dev_q <= '0;
            max_q <= '0;
            eip_q <= 1'b0;
            cnt_q <= '0;
        end else if (!bus.stall) begin
            dev_q <= root.id;
            max_q <= root.prio;
            eip_q <= eip_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.dev       = dev_q;
    assign bus.max       = max_q;
    assign bus.eip       = eip_q;
    assign bus.out_valid = (cnt_q == CNT_W'(LATENCY));
endmodule
